// File: rtl/imm_alu_sequencer.sv
// Control sequencer for immediate ALU instructions (ADDI/ANDI/ORI): fetch with
// bounded memory wait, decode, execute, write-back, retired-instruction count.
module imm_alu_sequencer #(
   parameter int unsigned      DATA_W   = 32,
   parameter int unsigned      OPC_W    = 5,
   parameter logic [OPC_W-1:0] OPC_ADDI = 5'b01100,
   parameter logic [OPC_W-1:0] OPC_ANDI = 5'b01101,
   parameter logic [OPC_W-1:0] OPC_ORI  = 5'b01110,
   parameter int unsigned      WAIT_MAX = 15,
   parameter int unsigned      CNT_W    = 16
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              start,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] ir,
   output logic              pc_out,
   output logic              mar_in,
   output logic              inc_pc,
   output logic              z_in,
   output logic              zlow_out,
   output logic              pc_in,
   output logic              mdr_in,
   output logic              read,
   output logic              mdr_out,
   output logic              ir_in,
   output logic              gra,
   output logic              grb,
   output logic              r_out,
   output logic              r_in,
   output logic              y_in,
   output logic              c_out,
   output logic              add,
   output logic              and_signal,
   output logic              or_signal,
   output logic              busy,
   output logic              done,
   output logic              illegal,
   output logic              timeout,
   output logic [CNT_W-1:0]  instr_count
);

   localparam int unsigned WCNT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
   localparam logic [WCNT_W-1:0] WAIT_LIM = WCNT_W'(WAIT_MAX);

   typedef enum logic [2:0] {IDLE, T0, T1, T2, T3, T4, T5, FAULT} state_t;

   state_t            state, state_nxt;
   logic [WCNT_W-1:0] wait_cnt;
   logic [OPC_W-1:0]  opc_q;
   logic [OPC_W-1:0]  opc_ir;
   logic              opc_legal;
   logic              unused_ir;

   assign opc_ir    = ir[DATA_W-1 -: OPC_W];
   assign opc_legal = (opc_ir == OPC_ADDI) || (opc_ir == OPC_ANDI) || (opc_ir == OPC_ORI);
   assign unused_ir = ^ir;

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state       <= IDLE;
         wait_cnt    <= '0;
         opc_q       <= '0;
         instr_count <= '0;
      end else begin
         state <= state_nxt;
         if (state == T0)
            wait_cnt <= '0;
         else if (state == T1 && !mem_ready && wait_cnt != WAIT_LIM)
            wait_cnt <= wait_cnt + 1'b1;
         if (state == T3)
            opc_q <= opc_ir;
         if (state == T5)
            instr_count <= instr_count + 1'b1;
      end
   end

   always_comb begin
      state_nxt  = state;
      pc_out     = 1'b0;
      mar_in     = 1'b0;
      inc_pc     = 1'b0;
      z_in       = 1'b0;
      zlow_out   = 1'b0;
      pc_in      = 1'b0;
      mdr_in     = 1'b0;
      read       = 1'b0;
      mdr_out    = 1'b0;
      ir_in      = 1'b0;
      gra        = 1'b0;
      grb        = 1'b0;
      r_out      = 1'b0;
      r_in       = 1'b0;
      y_in       = 1'b0;
      c_out      = 1'b0;
      add        = 1'b0;
      and_signal = 1'b0;
      or_signal  = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      illegal    = 1'b0;
      timeout    = 1'b0;
      case (state)
         IDLE: if (start) state_nxt = T0;
         T0: begin
            busy = 1'b1; pc_out = 1'b1; mar_in = 1'b1; inc_pc = 1'b1; z_in = 1'b1;
            state_nxt = T1;
         end
         T1: begin
            busy = 1'b1; read = 1'b1; mdr_in = 1'b1;
            // wait_cnt is still zero only in the first T1 cycle
            if (wait_cnt == '0) begin
               zlow_out = 1'b1;
               pc_in    = 1'b1;
            end
            if (mem_ready)
               state_nxt = T2;
            else if (wait_cnt == WAIT_LIM)
               state_nxt = FAULT;
         end
         T2: begin
            busy = 1'b1; mdr_out = 1'b1; ir_in = 1'b1;
            state_nxt = T3;
         end
         T3: begin
            // IR was loaded at the end of T2, so legality is decided on the live opcode
            busy = 1'b1;
            if (opc_legal) begin
               grb = 1'b1; r_out = 1'b1; y_in = 1'b1;
               state_nxt = T4;
            end else begin
               illegal   = 1'b1;
               state_nxt = IDLE;
            end
         end
         T4: begin
            busy = 1'b1; c_out = 1'b1; z_in = 1'b1;
            if (opc_q == OPC_ADDI)      add        = 1'b1;
            else if (opc_q == OPC_ANDI) and_signal = 1'b1;
            else if (opc_q == OPC_ORI)  or_signal  = 1'b1;
            state_nxt = T5;
         end
         T5: begin
            busy = 1'b1; zlow_out = 1'b1; gra = 1'b1; r_in = 1'b1; done = 1'b1;
            state_nxt = start ? T0 : IDLE;
         end
         FAULT: timeout = 1'b1;
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_imm_alu_sequencer.sv
// Self-checking bench for imm_alu_sequencer: per-cycle expected output traces
// built from the instruction-phase rules, randomized start/mem_ready/ir noise.
module tb_imm_alu_sequencer;

   localparam int unsigned DATA_W   = 32;
   localparam int unsigned OPC_W    = 5;
   localparam int unsigned WAIT_MAX = 15;
   localparam int unsigned CNT_W    = 2;
   localparam logic [4:0]  OP_ADDI  = 5'b01100;
   localparam logic [4:0]  OP_ANDI  = 5'b01101;
   localparam logic [4:0]  OP_ORI   = 5'b01110;

   localparam logic [22:0] B_PC_OUT  = 23'd1 << 22;
   localparam logic [22:0] B_MAR_IN  = 23'd1 << 21;
   localparam logic [22:0] B_INC_PC  = 23'd1 << 20;
   localparam logic [22:0] B_Z_IN    = 23'd1 << 19;
   localparam logic [22:0] B_ZLOW    = 23'd1 << 18;
   localparam logic [22:0] B_PC_IN   = 23'd1 << 17;
   localparam logic [22:0] B_MDR_IN  = 23'd1 << 16;
   localparam logic [22:0] B_READ    = 23'd1 << 15;
   localparam logic [22:0] B_MDR_OUT = 23'd1 << 14;
   localparam logic [22:0] B_IR_IN   = 23'd1 << 13;
   localparam logic [22:0] B_GRA     = 23'd1 << 12;
   localparam logic [22:0] B_GRB     = 23'd1 << 11;
   localparam logic [22:0] B_R_OUT   = 23'd1 << 10;
   localparam logic [22:0] B_R_IN    = 23'd1 << 9;
   localparam logic [22:0] B_Y_IN    = 23'd1 << 8;
   localparam logic [22:0] B_C_OUT   = 23'd1 << 7;
   localparam logic [22:0] B_ADD     = 23'd1 << 6;
   localparam logic [22:0] B_AND     = 23'd1 << 5;
   localparam logic [22:0] B_OR      = 23'd1 << 4;
   localparam logic [22:0] B_BUSY    = 23'd1 << 3;
   localparam logic [22:0] B_DONE    = 23'd1 << 2;
   localparam logic [22:0] B_ILLEGAL = 23'd1 << 1;
   localparam logic [22:0] B_TIMEOUT = 23'd1;

   logic clk = 1'b0;
   logic clr, start, mem_ready;
   logic [DATA_W-1:0] ir;
   logic pc_out, mar_in, inc_pc, z_in, zlow_out, pc_in, mdr_in, read, mdr_out, ir_in;
   logic gra, grb, r_out, r_in, y_in, c_out, add, and_signal, or_signal;
   logic busy, done, illegal, timeout;
   logic [CNT_W-1:0] instr_count;
   logic [22:0] obs;

   int unsigned checks = 0;
   int unsigned failures = 0;
   int unsigned exp_count = 0;

   typedef struct {
      logic [22:0] out;
      logic        mr;
      logic        st;
      bit          rnd;
      logic [4:0]  op;
   } cyc_t;
   cyc_t tr[$];

   always #5 clk = ~clk;

   imm_alu_sequencer #(
      .DATA_W(DATA_W), .OPC_W(OPC_W), .OPC_ADDI(OP_ADDI), .OPC_ANDI(OP_ANDI),
      .OPC_ORI(OP_ORI), .WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .clr(clr), .start(start), .mem_ready(mem_ready), .ir(ir),
      .pc_out(pc_out), .mar_in(mar_in), .inc_pc(inc_pc), .z_in(z_in),
      .zlow_out(zlow_out), .pc_in(pc_in), .mdr_in(mdr_in), .read(read),
      .mdr_out(mdr_out), .ir_in(ir_in), .gra(gra), .grb(grb), .r_out(r_out),
      .r_in(r_in), .y_in(y_in), .c_out(c_out), .add(add), .and_signal(and_signal),
      .or_signal(or_signal), .busy(busy), .done(done), .illegal(illegal),
      .timeout(timeout), .instr_count(instr_count)
   );

   assign obs = {pc_out, mar_in, inc_pc, z_in, zlow_out, pc_in, mdr_in, read, mdr_out,
                 ir_in, gra, grb, r_out, r_in, y_in, c_out, add, and_signal, or_signal,
                 busy, done, illegal, timeout};

   task automatic push(input logic [22:0] o, input logic mr, input logic st,
                       input bit rnd, input logic [4:0] op);
      cyc_t c;
      c.out = o; c.mr = mr; c.st = st; c.rnd = rnd; c.op = op;
      tr.push_back(c);
   endtask

   // Expected cycle-by-cycle behaviour of one instruction; start is random where it must be ignored
   task automatic add_instr(input logic [4:0] op, input int unsigned waits,
                            input bit from_idle, input bit b2b);
      logic [22:0] alu;
      if (from_idle) push('0, 1'($urandom), 1'b1, 1'b0, op);
      push(B_PC_OUT | B_MAR_IN | B_INC_PC | B_Z_IN | B_BUSY, 1'($urandom), 1'b0, 1'b1, op);
      for (int unsigned i = 0; i <= WAIT_MAX && i <= waits; i++)
         push(B_READ | B_MDR_IN | B_BUSY | ((i == 0) ? (B_ZLOW | B_PC_IN) : '0),
              (i == waits), 1'b0, 1'b1, op);
      if (waits > WAIT_MAX) return;
      push(B_MDR_OUT | B_IR_IN | B_BUSY, 1'($urandom), 1'b0, 1'b1, op);
      case (op)
         OP_ADDI: alu = B_ADD;
         OP_ANDI: alu = B_AND;
         OP_ORI:  alu = B_OR;
         default: alu = '0;
      endcase
      if (alu == '0) begin
         push(B_BUSY | B_ILLEGAL, 1'($urandom), 1'b0, 1'b1, op);
         return;
      end
      push(B_GRB | B_R_OUT | B_Y_IN | B_BUSY, 1'($urandom), 1'b0, 1'b1, op);
      push(B_C_OUT | B_Z_IN | B_BUSY | alu, 1'($urandom), 1'b0, 1'b1, op);
      push(B_ZLOW | B_GRA | B_R_IN | B_BUSY | B_DONE, 1'($urandom), b2b, 1'b0, op);
   endtask

   task automatic test_reset();
      clr = 1'b1; start = 1'b0; mem_ready = 1'b0; ir = '0;
      #2 clr = 1'b0;
      #1;
      checks++;
      if (obs !== '0) begin failures++; $display("FAIL reset_async outputs=%h expected %h", obs, 23'd0); end
      start = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (obs !== '0) begin failures++; $display("FAIL reset_hold outputs=%h expected %h", obs, 23'd0); end
      checks++;
      if (instr_count !== '0) begin failures++; $display("FAIL reset_count count=%0d expected 0", instr_count); end
      start = 1'b0;
      clr = 1'b1;
   endtask

   task automatic test_ori_zero_wait();
      add_instr(OP_ORI, 0, 1'b1, 1'b0);
      foreach (tr[i]) begin
         ir = {tr[i].op, 27'($urandom)};
         mem_ready = tr[i].mr;
         start = tr[i].rnd ? 1'($urandom) : tr[i].st;
         checks++;
         if (obs !== tr[i].out) begin failures++; $display("FAIL ori_zero_wait cyc %0d outputs=%h expected %h", i, obs, tr[i].out); end
         checks++;
         if (instr_count !== CNT_W'(exp_count)) begin failures++; $display("FAIL ori_count cyc %0d count=%0d expected %0d", i, instr_count, CNT_W'(exp_count)); end
         @(posedge clk); #1;
         if ((tr[i].out & B_DONE) != '0) exp_count++;
      end
      tr.delete();
   endtask

   task automatic test_wait_states();
      logic [4:0] ops[3];
      ops[0] = OP_ADDI; ops[1] = OP_ANDI; ops[2] = OP_ORI;
      add_instr(OP_ADDI, 3, 1'b1, 1'b0);
      add_instr(OP_ANDI, WAIT_MAX, 1'b1, 1'b0);
      for (int k = 0; k < 6; k++)
         add_instr(ops[$urandom_range(0, 2)], $urandom_range(0, WAIT_MAX), 1'b1, 1'b0);
      foreach (tr[i]) begin
         ir = {tr[i].op, 27'($urandom)};
         mem_ready = tr[i].mr;
         start = tr[i].rnd ? 1'($urandom) : tr[i].st;
         checks++;
         if (obs !== tr[i].out) begin failures++; $display("FAIL wait_states cyc %0d outputs=%h expected %h", i, obs, tr[i].out); end
         checks++;
         if (instr_count !== CNT_W'(exp_count)) begin failures++; $display("FAIL wait_count cyc %0d count=%0d expected %0d", i, instr_count, CNT_W'(exp_count)); end
         @(posedge clk); #1;
         if ((tr[i].out & B_DONE) != '0) exp_count++;
      end
      tr.delete();
   endtask

   task automatic test_illegal();
      logic [4:0] op;
      add_instr(5'b11111, 0, 1'b1, 1'b0);
      for (int k = 0; k < 4; k++) begin
         do op = 5'($urandom); while (op inside {OP_ADDI, OP_ANDI, OP_ORI});
         add_instr(op, $urandom_range(0, 3), 1'b1, 1'b0);
      end
      add_instr(OP_ADDI, 0, 1'b1, 1'b0);
      foreach (tr[i]) begin
         ir = {tr[i].op, 27'($urandom)};
         mem_ready = tr[i].mr;
         start = tr[i].rnd ? 1'($urandom) : tr[i].st;
         checks++;
         if (obs !== tr[i].out) begin failures++; $display("FAIL illegal cyc %0d outputs=%h expected %h", i, obs, tr[i].out); end
         checks++;
         if (instr_count !== CNT_W'(exp_count)) begin failures++; $display("FAIL illegal_count cyc %0d count=%0d expected %0d", i, instr_count, CNT_W'(exp_count)); end
         @(posedge clk); #1;
         if ((tr[i].out & B_DONE) != '0) exp_count++;
      end
      tr.delete();
   endtask

   task automatic test_back_to_back();
      add_instr(OP_ADDI, 0, 1'b1, 1'b1);
      add_instr(OP_ANDI, 1, 1'b0, 1'b1);
      add_instr(OP_ORI,  0, 1'b0, 1'b1);
      add_instr(OP_ADDI, 2, 1'b0, 1'b1);
      add_instr(OP_ANDI, 0, 1'b0, 1'b0);
      foreach (tr[i]) begin
         ir = {tr[i].op, 27'($urandom)};
         mem_ready = tr[i].mr;
         start = tr[i].rnd ? 1'($urandom) : tr[i].st;
         checks++;
         if (obs !== tr[i].out) begin failures++; $display("FAIL back_to_back cyc %0d outputs=%h expected %h", i, obs, tr[i].out); end
         checks++;
         if (instr_count !== CNT_W'(exp_count)) begin failures++; $display("FAIL b2b_count cyc %0d count=%0d expected %0d", i, instr_count, CNT_W'(exp_count)); end
         @(posedge clk); #1;
         if ((tr[i].out & B_DONE) != '0) exp_count++;
      end
      tr.delete();
   endtask

   task automatic test_timeout();
      add_instr(OP_ADDI, WAIT_MAX + 1, 1'b1, 1'b0);
      for (int k = 0; k < 5; k++) push(B_TIMEOUT, 1'($urandom), 1'b1, 1'b0, OP_ORI);
      foreach (tr[i]) begin
         ir = {tr[i].op, 27'($urandom)};
         mem_ready = tr[i].mr;
         start = tr[i].rnd ? 1'($urandom) : tr[i].st;
         checks++;
         if (obs !== tr[i].out) begin failures++; $display("FAIL timeout cyc %0d outputs=%h expected %h", i, obs, tr[i].out); end
         checks++;
         if (instr_count !== CNT_W'(exp_count)) begin failures++; $display("FAIL timeout_count cyc %0d count=%0d expected %0d", i, instr_count, CNT_W'(exp_count)); end
         @(posedge clk); #1;
      end
      tr.delete();
      #2 clr = 1'b0;
      exp_count = 0;
      #1;
      checks++;
      if (obs !== '0) begin failures++; $display("FAIL fault_clear outputs=%h expected %h", obs, 23'd0); end
      checks++;
      if (instr_count !== '0) begin failures++; $display("FAIL fault_clear_count count=%0d expected 0", instr_count); end
      start = 1'b0;
      @(posedge clk); #1;
      clr = 1'b1;
   endtask

   task automatic test_reset_mid_op();
      add_instr(OP_ADDI, 0, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         ir = {tr[i].op, 27'($urandom)};
         mem_ready = tr[i].mr;
         start = tr[i].rnd ? 1'($urandom) : tr[i].st;
         checks++;
         if (obs !== tr[i].out) begin failures++; $display("FAIL mid_op_pre cyc %0d outputs=%h expected %h", i, obs, tr[i].out); end
         @(posedge clk); #1;
      end
      checks++;
      if (obs !== tr[5].out) begin failures++; $display("FAIL mid_op_t4 outputs=%h expected %h", obs, tr[5].out); end
      tr.delete();
      #2 clr = 1'b0;
      #1;
      checks++;
      if (obs !== '0) begin failures++; $display("FAIL mid_op_async outputs=%h expected %h", obs, 23'd0); end
      start = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || obs !== '0) begin failures++; $display("FAIL mid_op_no_done outputs=%h expected %h", obs, 23'd0); end
      checks++;
      if (instr_count !== CNT_W'(exp_count)) begin failures++; $display("FAIL mid_op_count count=%0d expected %0d", instr_count, CNT_W'(exp_count)); end
      start = 1'b0;
      clr = 1'b1;
      add_instr(OP_ORI, 2, 1'b1, 1'b0);
      foreach (tr[i]) begin
         ir = {tr[i].op, 27'($urandom)};
         mem_ready = tr[i].mr;
         start = tr[i].rnd ? 1'($urandom) : tr[i].st;
         checks++;
         if (obs !== tr[i].out) begin failures++; $display("FAIL after_reset cyc %0d outputs=%h expected %h", i, obs, tr[i].out); end
         checks++;
         if (instr_count !== CNT_W'(exp_count)) begin failures++; $display("FAIL after_reset_count cyc %0d count=%0d expected %0d", i, instr_count, CNT_W'(exp_count)); end
         @(posedge clk); #1;
         if ((tr[i].out & B_DONE) != '0) exp_count++;
      end
      tr.delete();
      checks++;
      if (instr_count !== CNT_W'(exp_count)) begin failures++; $display("FAIL final_count count=%0d expected %0d", instr_count, CNT_W'(exp_count)); end
   endtask

   initial begin
      test_reset();
      test_ori_zero_wait();
      test_wait_states();
      test_illegal();
      test_back_to_back();
      test_timeout();
      test_reset_mid_op();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog simulation did not complete in time");
      $fatal(1);
   end

endmodule
